dmem_arbiter: RTL and testbench

- Shares the single data-memory port (dmem: addr, write enable, write data, combinational read data, synchronous write) between two requesters.
- Port 0 is the CPU load/store unit. Port 1 is the debug/loader port used to preload or inspect data memory while the core runs.
- Port 0 has fixed priority. A starvation guard forces a port-1 grant after a bounded wait.
- Read data is registered and returned one cycle after the accepted transfer.

---
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: fixed priority to the
// CPU with a starvation guard for the debug/loader port, registered read return.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam int WAIT_W = 8;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              force1;

  // Port 1 wins only when it has been starved for MAX_WAIT cycles.
  assign force1 = (wait_q == WAIT_W'(MAX_WAIT));
  assign gnt1   = ~rst & req1 & (~req0 | force1);
  assign gnt0   = ~rst & req0 & ~(req1 & force1);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (!rst) begin
      mem_addr  = gnt1 ? addr1  : addr0;
      mem_wdata = gnt1 ? wdata1 : wdata0;
      mem_wen   = (gnt0 & we0) | (gnt1 & we1);
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!req1 || gnt1) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata_d   = (rvalid0_d | rvalid1_d) ? mem_rdata : rdata_q;
    cnt_d     = cnt_q;
    if (req0 && req1 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      wait_q    <= wait_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rvalid0        = rvalid0_q;
  assign rvalid1        = rvalid1_q;
  assign rdata          = rdata_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus starvation, saturation
// and mid-read reset sequences against a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;

  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wen;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] contention_cnt;

  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_wen_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  contention_cnt_b;

  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata   = mem[mem_addr[7:2]];
  assign mem_rdata_b = mem[mem_addr_b[7:2]];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .contention_cnt(contention_cnt)
  );

  dmem_arbiter #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .mem_addr(mem_addr_b), .mem_wen(mem_wen_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .contention_cnt(contention_cnt_b)
  );

  typedef struct {
    logic        rst;
    logic        req0, we0;
    logic [31:0] a0, d0;
    logic        req1, we1;
    logic [31:0] a1, d1;
    logic        g0, g1, wen;
    logic [31:0] maddr;
    logic        rv0, rv1;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //           rst req0 we0 a0     d0            req1 we1 a1     d1         g0 g1 wen maddr  rv0 rv1 rdata         cnt
    vec[0]  = '{1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 32'h20, 32'h5,    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,        16'd0};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0,        16'd0};
    vec[2]  = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0,        16'd0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 16'd0};
    vec[4]  = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 1'b1, 32'h20, 32'h1234, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'hDEADBEEF, 16'd0};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 32'hDEADBEEF, 16'd0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h1234,     16'd0};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h10, 32'h0,    1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 32'h1234,     16'd0};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hDEADBEEF, 16'd0};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0, 32'hDEADBEEF, 16'd0};
    vec[10] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h1234,     16'd0};
    vec[11] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 16'd0};
    vec[12] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'hDEADBEEF, 16'd0};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = vec[i].rst;
      req0 = vec[i].req0; we0 = vec[i].we0; addr0 = vec[i].a0; wdata0 = vec[i].d0;
      req1 = vec[i].req1; we1 = vec[i].we1; addr1 = vec[i].a1; wdata1 = vec[i].d1;
      #1;
      chk($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(vec[i].g0));
      chk($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(vec[i].g1));
      chk($sformatf("v%0d mem_wen", i), 32'(mem_wen), 32'(vec[i].wen));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vec[i].maddr);
      chk($sformatf("v%0d rvalid0", i), 32'(rvalid0), 32'(vec[i].rv0));
      chk($sformatf("v%0d rvalid1", i), 32'(rvalid1), 32'(vec[i].rv1));
      chk($sformatf("v%0d rdata", i), rdata, vec[i].rdata);
      chk($sformatf("v%0d cnt", i), 32'(contention_cnt), 32'(vec[i].cnt));
      $display("vector %0d: gnt0=%b gnt1=%b wen=%b addr=%h rv0=%b rv1=%b rdata=%h",
               i, gnt0, gnt1, mem_wen, mem_addr, rvalid0, rvalid1, rdata);
    end

    // Both ports reading continuously: port 1 is forced through every fifth cycle.
    for (int c = 0; c < 20; c++) begin
      logic e_g1, e_rv0, e_rv1;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
      #1;
      e_g1  = (c % 5 == 4);
      e_rv0 = (c >= 1) && ((c - 1) % 5 != 4);
      e_rv1 = (c >= 1) && ((c - 1) % 5 == 4);
      chk($sformatf("starve c%0d gnt0", c), 32'(gnt0), 32'(!e_g1));
      chk($sformatf("starve c%0d gnt1", c), 32'(gnt1), 32'(e_g1));
      chk($sformatf("starve c%0d addr", c), mem_addr, e_g1 ? 32'h20 : 32'h10);
      chk($sformatf("starve c%0d rv0", c), 32'(rvalid0), 32'(e_rv0));
      chk($sformatf("starve c%0d rv1", c), 32'(rvalid1), 32'(e_rv1));
      chk($sformatf("starve c%0d rdata", c), rdata, e_rv1 ? 32'h1234 : 32'hDEADBEEF);
      chk($sformatf("starve c%0d cnt", c), 32'(contention_cnt), c);
      chk($sformatf("starve c%0d cnt4", c), 32'(contention_cnt_b), (c > 15) ? 15 : c);
      $display("starve %0d: gnt0=%b gnt1=%b rv0=%b rv1=%b cnt=%0d cnt4=%0d",
               c, gnt0, gnt1, rvalid0, rvalid1, contention_cnt, contention_cnt_b);
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("sat cnt", 32'(contention_cnt), 20);
    chk("sat cnt4", 32'(contention_cnt_b), 15);
    chk("sat rv1", 32'(rvalid1), 1);
    chk("sat rdata", rdata, 32'h1234);
    $display("saturation: cnt=%0d cnt4=%0d", contention_cnt, contention_cnt_b);

    // Reset arriving while a read result is on the bus.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; req1 = 1'b0;
    #1;
    chk("rstmid gnt0", 32'(gnt0), 1);
    @(posedge clk);
    #1;
    chk("rstmid rv0 before", 32'(rvalid0), 1);
    chk("rstmid rdata before", rdata, 32'hDEADBEEF);
    rst = 1'b1; req1 = 1'b1; we0 = 1'b1; wdata0 = 32'h00000BAD;
    #1;
    chk("rstmid rv0 drop", 32'(rvalid0), 0);
    chk("rstmid rdata", rdata, 0);
    chk("rstmid cnt", 32'(contention_cnt), 0);
    $display("reset mid-read: rv0=%b rdata=%h", rvalid0, rdata);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("inrst%0d gnt0", k), 32'(gnt0), 0);
      chk($sformatf("inrst%0d gnt1", k), 32'(gnt1), 0);
      chk($sformatf("inrst%0d wen", k), 32'(mem_wen), 0);
      chk($sformatf("inrst%0d addr", k), mem_addr, 0);
      $display("in reset %0d: gnt0=%b gnt1=%b wen=%b", k, gnt0, gnt1, mem_wen);
    end
    @(negedge clk);
    rst = 1'b0; req1 = 1'b0; we0 = 1'b0; addr0 = 32'h10;
    #1;
    chk("postrst gnt0", 32'(gnt0), 1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk("postrst rv0", 32'(rvalid0), 1);
    chk("postrst rdata", rdata, 32'hDEADBEEF);
    $display("post reset read: rv0=%b rdata=%h", rvalid0, rdata);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
